// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and
// default timing for a 12 MHz clk_in.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYCLES   = 240_000;     // 20 ms @ 12 MHz
    localparam int DEF_LONG_PRESS_CYCLES = 12_000_000;  // 1 s @ 12 MHz
    localparam bit DEF_KEY_ACTIVE_LOW    = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous pins; RESET_VAL should be the
// pin's idle level so reset release does not look like an input edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton conditioner: synchronise, debounce, and emit press/release/long
// pulses, a debounced level and an LED toggle.
//
// state      | meaning
// IDLE       | key released and stable
// PRESS_DB   | key seen pressed, waiting for DEBOUNCE_CYCLES of stability
// PRESSED    | press accepted, key held
// RELEASE_DB | key seen released, waiting for DEBOUNCE_CYCLES of stability
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit KEY_ACTIVE_LOW    = DEF_KEY_ACTIVE_LOW
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic led_toggle
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic              SYNC_RST  = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic w_key_sync;
    logic w_k;
    logic w_to_idle;

    key_state_e        r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_led;

    sync_2ff #(
        .RESET_VAL (SYNC_RST)
    ) u_sync_key (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_d      (key_in),
        .o_q      (w_key_sync)
    );

    assign w_k = KEY_ACTIVE_LOW ? ~w_key_sync : w_key_sync;

    // Release acceptance wins over a long-press pulse landing on the same edge
    assign w_to_idle = (r_state == RELEASE_DB) && !w_k && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_led       <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            if (r_press) begin
                r_led <= ~r_led;
            end

            case (r_state)
                IDLE: begin
                    if (w_k) begin
                        r_state  <= PRESS_DB;
                        r_db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!w_k) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state    <= PRESSED;
                        r_hold_cnt <= '0;
                        r_level    <= 1'b1;
                        r_press    <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_k) begin
                        r_state  <= RELEASE_DB;
                        r_db_cnt <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (w_k) begin
                        r_state <= PRESSED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= IDLE;
                        r_level     <= 1'b0;
                        r_release   <= 1'b1;
                        r_long_done <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                end
            endcase

            // Hold time keeps running through release glitches; saturates at the threshold
            if (r_state == PRESSED || r_state == RELEASE_DB) begin
                if (r_hold_cnt != HOLD_LAST) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end else if (!r_long_done && !w_to_idle) begin
                    r_long      <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;
    assign led_toggle  = r_led;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: expected pulse events are queued with
// their cycle numbers as stimulus is driven and matched against observed pulses.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int LAT  = 2 + DEB + 1;

    localparam logic [1:0] EV_PRESS   = 2'd1;
    localparam logic [1:0] EV_RELEASE = 2'd2;
    localparam logic [1:0] EV_LONG    = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;
    logic led_toggle;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_led;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    key_debounce #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .KEY_ACTIVE_LOW    (1)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .led_toggle  (led_toggle)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Observed pulse log, plus pulse exclusivity whenever any pulse is present
    always @(negedge clk_in) begin
        ev_t ev;
        if (rst_n_in === 1'b1) begin
            ev.cyc = cyc;
            if (key_press === 1'b1)   begin ev.kind = EV_PRESS;   obs_q.push_back(ev); end
            if (key_release === 1'b1) begin ev.kind = EV_RELEASE; obs_q.push_back(ev); end
            if (key_long === 1'b1)    begin ev.kind = EV_LONG;    obs_q.push_back(ev); end
            if ((key_press | key_release | key_long) === 1'b1) begin
                checks++;
                if ($countones({key_press, key_release, key_long}) > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive cyc %0d got press=%b release=%b long=%b want at most one",
                             cyc, key_press, key_release, key_long);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_exp(input logic [1:0] kind, input int at_cyc);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = at_cyc;
        exp_q.push_back(ev);
        if (kind == EV_PRESS) exp_led = ~exp_led;
    endtask

    task automatic test_reset();
        ev_t e, o;
        int  t0;
        rst_n_in = 1'b0;
        key_in   = 1'b0;
        exp_led  = 1'b0;
        tick(3);
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long, led_toggle} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {key_level, key_press, key_release, key_long, led_toggle});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        t0 = cyc;
        push_exp(EV_PRESS, t0 + LAT);
        tick(LAT);
        #1;
        checks++;
        if ({key_press, key_level} !== 2'b11) begin
            errors++;
            $display("FAIL reset_first_press got press=%b level=%b want 1 1", key_press, key_level);
        end
        tick(2);
        checks++;
        if (led_toggle !== exp_led) begin
            errors++;
            $display("FAIL reset_led got %b want %b", led_toggle, exp_led);
        end
        key_in = 1'b1;
        push_exp(EV_RELEASE, cyc + LAT);
        tick(LAT + 3);
        #1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bounce();
        ev_t e, o;
        for (int r = 0; r < 5; r++) begin
            key_in = 1'b0;
            tick(2);
            key_in = 1'b1;
            tick(3);
            checks++;
            if (key_level !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level rep %0d got %b want 0", r, key_level);
            end
        end
        tick(LAT);
        #1;
        checks++;
        if (led_toggle !== exp_led) begin
            errors++;
            $display("FAIL bounce_led got %b want %b", led_toggle, exp_led);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bounce_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bounce_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clean_press();
        ev_t e, o;
        int  t;
        key_in = 1'b0;
        t = cyc;
        push_exp(EV_PRESS, t + LAT);
        tick(10);
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_held got %b want 1", key_level);
        end
        key_in = 1'b1;
        push_exp(EV_RELEASE, t + 10 + LAT);
        tick(LAT + 4);
        #1;
        checks++;
        if ({key_level, led_toggle} !== {1'b0, exp_led}) begin
            errors++;
            $display("FAIL clean_after got level=%b led=%b want 0 %b", key_level, led_toggle, exp_led);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL clean_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clean_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_long_press();
        ev_t e, o;
        int  t;
        key_in = 1'b0;
        t = cyc;
        push_exp(EV_PRESS, t + LAT);
        push_exp(EV_LONG, t + LAT + LONG);
        tick(12);
        key_in = 1'b1;
        tick(2);
        key_in = 1'b0;
        tick(3);
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL long_glitch1_level got %b want 1", key_level);
        end
        tick(15);
        key_in = 1'b1;
        tick(2);
        key_in = 1'b0;
        tick(3);
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL long_glitch2_level got %b want 1", key_level);
        end
        tick(3);
        key_in = 1'b1;
        push_exp(EV_RELEASE, t + 40 + LAT);
        tick(LAT + 3);
        #1;
        checks++;
        if (led_toggle !== exp_led) begin
            errors++;
            $display("FAIL long_led got %b want %b", led_toggle, exp_led);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL long_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL long_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_press();
        ev_t e, o;
        int  t;
        key_in = 1'b0;
        t = cyc;
        push_exp(EV_PRESS, t + LAT);
        tick(10);
        rst_n_in = 1'b0;
        exp_led  = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long, led_toggle} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_async got %b want 00000",
                     {key_level, key_press, key_release, key_long, led_toggle});
        end
        tick(3);
        checks++;
        if ({key_level, key_press, key_release, key_long, led_toggle} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_held got %b want 00000",
                     {key_level, key_press, key_release, key_long, led_toggle});
        end
        rst_n_in = 1'b1;
        t = cyc;
        push_exp(EV_PRESS, t + LAT);
        tick(LAT + 2);
        checks++;
        if ({key_level, led_toggle} !== {1'b1, exp_led}) begin
            errors++;
            $display("FAIL midrst_repress got level=%b led=%b want 1 %b", key_level, led_toggle, exp_led);
        end
        key_in = 1'b1;
        push_exp(EV_RELEASE, cyc + LAT);
        tick(LAT + 3);
        #1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midrst_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        int  t;
        key_in   = 1'b1;
        rst_n_in = 1'b0;
        exp_led  = 1'b0;
        tick(2);
        rst_n_in = 1'b1;
        tick(2);
        checks++;
        if (led_toggle !== 1'b0) begin
            errors++;
            $display("FAIL b2b_led_start got %b want 0", led_toggle);
        end
        for (int p = 0; p < 2; p++) begin
            key_in = 1'b0;
            t = cyc;
            push_exp(EV_PRESS, t + LAT);
            tick(9);
            checks++;
            if (led_toggle !== exp_led) begin
                errors++;
                $display("FAIL b2b_led press %0d got %b want %b", p, led_toggle, exp_led);
            end
            key_in = 1'b1;
            push_exp(EV_RELEASE, t + 9 + LAT);
            tick(LAT + 2);
        end
        #1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_evcount got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst_n_in = 1'b0;
        key_in   = 1'b1;
        exp_led  = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_bounce();
        test_clean_press();
        test_long_press();
        test_reset_mid_press();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
